// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
// Central stall/flush controller for the 5-stage LC-3b pipeline.
// Uses load-use bubble requests, I/D-cache stall status and the MEM-stage
// redirect to drive per-stage register loads, the ID/EX nop insert and the
// younger-stage flushes. It also tracks stall episodes in a small FSM and
// keeps saturating performance counters.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   bubble_enable_i     load-use hazard detected in ID
//   imem_read_i/resp_i  fetch outstanding / I-cache response
//   dmem_access_i/resp_i MEM-stage data access / D-cache response
//   br_taken_i          MEM-stage control transfer taken
//   clear_counters_i    synchronous zero of all counters
//   load_*_o            pipeline register load enables (combinational)
//   bubble_id_ex_o      ID/EX loads a nop instead of ID contents
//   flush_*_o           younger-stage register loads a nop
//   stall_cycles_o      cycles with load_pc low
//   bubble_count_o      load-use bubbles inserted
//   flush_count_o       redirects performed
//   dmiss_events_o      entries into the D-cache wait episode
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bubble_enable_i,
    input  logic             imem_read_i,
    input  logic             imem_resp_i,
    input  logic             dmem_access_i,
    input  logic             dmem_resp_i,
    input  logic             br_taken_i,
    input  logic             clear_counters_i,
    output logic             load_pc_o,
    output logic             load_if_id_o,
    output logic             load_id_ex_o,
    output logic             load_ex_mem_o,
    output logic             load_mem_wb_o,
    output logic             bubble_id_ex_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             flush_ex_mem_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] bubble_count_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [CNT_W-1:0] dmiss_events_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_RWAIT = 2'd2,
        ST_IWAIT = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic dstall;
    logic istall;
    logic bubble_evt;
    logic flush_evt;
    logic dmiss_evt;

    logic [CNT_W-1:0] stall_cycles_q, bubble_count_q, flush_count_q, dmiss_events_q;

    assign dstall = dmem_access_i & ~dmem_resp_i;
    assign istall = imem_read_i & ~imem_resp_i;

    // Episode state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority decode: next state, stage controls and counter events.
    always_comb begin
        state_d        = ST_RUN;
        load_pc_o      = 1'b0;
        load_if_id_o   = 1'b0;
        load_id_ex_o   = 1'b0;
        load_ex_mem_o  = 1'b0;
        load_mem_wb_o  = 1'b0;
        bubble_id_ex_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_mem_o = 1'b0;
        bubble_evt     = 1'b0;
        flush_evt      = 1'b0;

        if (reset) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
        end else if (dstall) begin
            // Whole pipe frozen; nothing may be discarded while MEM waits.
            state_d = ST_DWAIT;
        end else if (br_taken_i && istall) begin
            // Hold the redirect until the in-flight fetch returns.
            state_d = ST_RWAIT;
        end else if (br_taken_i) begin
            load_pc_o      = 1'b1;
            load_if_id_o   = 1'b1;
            load_id_ex_o   = 1'b1;
            load_ex_mem_o  = 1'b1;
            load_mem_wb_o  = 1'b1;
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            flush_evt      = 1'b1;
        end else if (istall || bubble_enable_i) begin
            // Hold the front end, let older instructions drain behind a nop.
            state_d        = istall ? ST_IWAIT : ST_RUN;
            load_id_ex_o   = 1'b1;
            bubble_id_ex_o = 1'b1;
            load_ex_mem_o  = 1'b1;
            load_mem_wb_o  = 1'b1;
            bubble_evt     = ~istall;
        end else begin
            load_pc_o      = 1'b1;
            load_if_id_o   = 1'b1;
            load_id_ex_o   = 1'b1;
            load_ex_mem_o  = 1'b1;
            load_mem_wb_o  = 1'b1;
        end
    end

    assign dmiss_evt = (state_d == ST_DWAIT) && (state_q != ST_DWAIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        sat_inc = (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (reset || clear_counters_i) begin
            stall_cycles_q <= '0;
            bubble_count_q <= '0;
            flush_count_q  <= '0;
            dmiss_events_q <= '0;
        end else begin
            stall_cycles_q <= sat_inc(stall_cycles_q, ~load_pc_o);
            bubble_count_q <= sat_inc(bubble_count_q, bubble_evt);
            flush_count_q  <= sat_inc(flush_count_q, flush_evt);
            dmiss_events_q <= sat_inc(dmiss_events_q, dmiss_evt);
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign bubble_count_o = bubble_count_q;
    assign flush_count_o  = flush_count_q;
    assign dmiss_events_o = dmiss_events_q;

endmodule
